step_decoder_seq: RTL and testbench

// Parametrised, registered one-hot decoder that drives register/step enables in the processor datapath.

---
 rtl/step_dec_pkg.sv | 9 +
 rtl/dec_onehot.sv | 15 +
 rtl/step_decoder_seq.sv | 124 ++++++++++++
 tb/tb_step_decoder_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/step_dec_pkg.sv
// Shared types for the step decoder: FSM state encoding and mode selector values.
package step_dec_pkg;

  typedef enum logic {IDLE, SWEEP} step_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SWEEP  = 1'b1;

endpackage

// File: rtl/dec_onehot.sv
// Combinational index-to-one-hot decoder; the output is all zero when en is low.
module dec_onehot #(
  parameter  int SEL_W = 3,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] y
);

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
    assign y[gi] = en && (sel == SEL_W'(gi));
  end

endmodule

// File: rtl/step_decoder_seq.sv
// Registered one-hot enable decoder: DIRECT decodes W each cycle; SWEEP walks the
// one-hot bit from a start index to a last index, stalling on En=0 and pulsing Done.
module step_decoder_seq
  import step_dec_pkg::*;
#(
  parameter  int SEL_W = 3,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic             Mode,
  input  logic             Start,
  input  logic             Clear,
  input  logic [SEL_W-1:0] W,
  input  logic [SEL_W-1:0] Last,
  output logic [OUT_W-1:0] Y,
  output logic [SEL_W-1:0] Idx,
  output logic             Busy,
  output logic             Done
);

  step_state_t      state_reg, state_next;
  logic [OUT_W-1:0] y_reg, y_next;
  logic [SEL_W-1:0] idx_reg, idx_next;
  logic [SEL_W-1:0] last_q_reg, last_q_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic [SEL_W-1:0] idx_inc;
  logic [SEL_W-1:0] dec_sel;
  logic             dec_en;
  logic [OUT_W-1:0] dec_y;

  assign idx_inc = idx_reg + SEL_W'(1);

  // One shared decoder: it sees W while idle and the next sweep index while sweeping.
  dec_onehot #(.SEL_W(SEL_W)) u_dec (
    .en  (dec_en),
    .sel (dec_sel),
    .y   (dec_y)
  );

  always_comb begin
    state_next  = state_reg;
    y_next      = y_reg;
    idx_next    = idx_reg;
    last_q_next = last_q_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    dec_en      = 1'b0;
    dec_sel     = W;

    case (state_reg)
      IDLE: begin
        if (Mode == MODE_DIRECT) begin
          dec_en = En;
          y_next = dec_y;
          if (En) idx_next = W;
        end else begin
          dec_en = En && Start;
          y_next = dec_y;
          if (En && Start) begin
            idx_next    = W;
            last_q_next = Last;
            busy_next   = 1'b1;
            state_next  = SWEEP;
          end
        end
      end
      SWEEP: begin
        dec_sel = idx_inc;
        if (En) begin
          if (idx_reg != last_q_reg) begin
            dec_en   = 1'b1;
            idx_next = idx_inc;
            y_next   = dec_y;
          end else begin
            y_next     = '0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        y_next     = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Clear aborts like Reset but keeps Idx so software can see where a sweep stopped.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg  <= IDLE;
      y_reg      <= '0;
      idx_reg    <= '0;
      last_q_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else if (Clear) begin
      state_reg  <= IDLE;
      y_reg      <= '0;
      last_q_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      y_reg      <= y_next;
      idx_reg    <= idx_next;
      last_q_reg <= last_q_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign Y    = y_reg;
  assign Idx  = idx_reg;
  assign Busy = busy_reg;
  assign Done = done_reg;

endmodule

// File: tb/tb_step_decoder_seq.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a step-count based behavioural model.
module tb_step_decoder_seq;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             En = 1'b1;
  logic             Mode = 1'b0;
  logic             Start = 1'b0;
  logic             Clear = 1'b0;
  logic [SEL_W-1:0] W = 3'd5;
  logic [SEL_W-1:0] Last = 3'd0;
  logic [OUT_W-1:0] Y;
  logic [SEL_W-1:0] Idx;
  logic             Busy;
  logic             Done;

  int n_pass  = 0;
  int n_total = 0;
  logic check_en = 1'b0;

  step_decoder_seq dut (
    .Clock (Clock),
    .Reset (Reset),
    .En    (En),
    .Mode  (Mode),
    .Start (Start),
    .Clear (Clear),
    .W     (W),
    .Last  (Last),
    .Y     (Y),
    .Idx   (Idx),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 Clock = ~Clock;

  // Model: a sweep is a count of remaining steps, not a comparison against Last.
  logic [OUT_W-1:0] m_y = '0;
  logic [SEL_W-1:0] m_idx = '0;
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  logic [SEL_W-1:0] m_rem = '0;

  always @(posedge Clock) begin
    m_done <= 1'b0;
    if (Reset) begin
      m_y <= '0; m_idx <= '0; m_busy <= 1'b0; m_rem <= '0;
    end else if (Clear) begin
      m_y <= '0; m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (!Mode) begin
        if (En) begin m_y <= 8'd1 << W; m_idx <= W; end
        else m_y <= '0;
      end else if (En && Start) begin
        m_busy <= 1'b1; m_idx <= W; m_y <= 8'd1 << W; m_rem <= 3'(Last - W);
      end else begin
        m_y <= '0;
      end
    end else if (En) begin
      if (m_rem == 0) begin
        m_busy <= 1'b0; m_y <= '0; m_done <= 1'b1;
      end else begin
        m_rem <= m_rem - 3'd1;
        m_idx <= 3'(m_idx + 3'd1);
        m_y   <= 8'd1 << 3'(m_idx + 3'd1);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge Clock) begin
    if (check_en) begin
      chk("model_y", 32'(Y), 32'(m_y));
      chk("model_idx", 32'(Idx), 32'(m_idx));
      chk("model_busy", 32'(Busy), 32'(m_busy));
      chk("model_done", 32'(Done), 32'(m_done));
      chk("onehot_inv", 32'((Y == '0) || (Y == (8'd1 << Idx))), 32'd1);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic chk_out(input string name, input logic [7:0] ey, input logic eb, input logic ed);
    chk({name, "_y"}, 32'(Y), 32'(ey));
    chk({name, "_busy"}, 32'(Busy), 32'(eb));
    chk({name, "_done"}, 32'(Done), 32'(ed));
  endtask

  logic [7:0] exp4 [6];

  initial begin
    exp4 = '{8'h40, 8'h80, 8'h80, 8'h80, 8'h01, 8'h02};

    // 1: reset holds everything at zero even with En=1, W=5
    for (int i = 0; i < 2; i++) begin
      tick();
      check_en = 1'b1;
      chk_out("reset", 8'h00, 1'b0, 1'b0);
      chk("reset_idx", 32'(Idx), 32'd0);
    end
    Reset = 1'b0;

    // 2: DIRECT decode of every index, then En=0 zeroes Y and keeps Idx
    Mode = 1'b0; En = 1'b1;
    for (int w = 0; w < 8; w++) begin
      W = 3'(w);
      tick();
      chk("direct_y", 32'(Y), 32'(8'd1 << w));
      $display("direct W=%0d Y=%02h Idx=%0d", w, Y, Idx);
    end
    En = 1'b0;
    tick();
    chk_out("direct_off", 8'h00, 1'b0, 1'b0);
    chk("direct_off_idx", 32'(Idx), 32'd7);

    // 3: sweep 2..4
    Mode = 1'b1; En = 1'b1; W = 3'd2; Last = 3'd4; Start = 1'b1;
    tick(); Start = 1'b0;
    chk_out("sw3_a", 8'h04, 1'b1, 1'b0);
    tick(); chk_out("sw3_b", 8'h08, 1'b1, 1'b0);
    tick(); chk_out("sw3_c", 8'h10, 1'b1, 1'b0);
    tick(); chk_out("sw3_done", 8'h00, 1'b0, 1'b1);
    tick(); chk_out("sw3_after", 8'h00, 1'b0, 1'b0);
    $display("sweep 2..4 finished Idx=%0d", Idx);

    // 4: wrapping sweep 6..1 with a two-cycle stall at index 7
    W = 3'd6; Last = 3'd1; Start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      Start = 1'b0;
      En = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      chk("sw4_y", 32'(Y), 32'(exp4[i]));
      $display("wrap sweep step %0d Y=%02h Idx=%0d", i, Y, Idx);
    end
    tick(); chk_out("sw4_done", 8'h00, 1'b0, 1'b1);

    // 5: single-step sweep; a second Start while busy must not relaunch
    W = 3'd3; Last = 3'd3; Start = 1'b1; En = 1'b1;
    tick(); chk_out("sw5_a", 8'h08, 1'b1, 1'b0); chk("sw5_idx_a", 32'(Idx), 32'd3);
    W = 3'd0;
    tick(); chk_out("sw5_done", 8'h00, 1'b0, 1'b1); chk("sw5_idx_b", 32'(Idx), 32'd3);
    Start = 1'b0;
    tick(); chk_out("sw5_after", 8'h00, 1'b0, 1'b0); chk("sw5_idx_c", 32'(Idx), 32'd3);

    // 6: Clear at index 5 of sweep 4..7, then immediate DIRECT decode
    W = 3'd4; Last = 3'd7; Start = 1'b1;
    tick(); Start = 1'b0; chk_out("sw6_a", 8'h10, 1'b1, 1'b0);
    tick(); chk_out("sw6_b", 8'h20, 1'b1, 1'b0);
    Clear = 1'b1;
    tick(); Clear = 1'b0;
    chk_out("sw6_clr", 8'h00, 1'b0, 1'b0); chk("sw6_clr_idx", 32'(Idx), 32'd5);
    Mode = 1'b0; W = 3'd1;
    tick(); chk_out("sw6_direct", 8'h02, 1'b0, 1'b0);
    $display("clear abort then direct W=1 Y=%02h", Y);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 127) == 0);
      Clear = ($urandom_range(0, 63) == 0);
      En    = ($urandom_range(0, 3) != 0);
      Mode  = ($urandom_range(0, 3) != 0);
      Start = ($urandom_range(0, 2) == 0);
      W     = 3'($urandom_range(0, 7));
      Last  = 3'($urandom_range(0, 7));
      tick();
    end

    @(negedge Clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
